// File: rtl/ual_ctrl_pkg.sv
// Shared opcodes, UAL select constants and sequencer state encoding for the UAL control core.
package ual_ctrl_pkg;

    localparam logic [2:0] OP_NOR = 3'b000;
    localparam logic [2:0] OP_NOP = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_JCC = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // UAL neutral select: result 0, carry 0
    localparam logic [2:0] SEL_IDLE = 3'b001;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        OPRD   = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4,
        HALTED = 3'd5
    } state_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == OPRD) || (s == WRITE);
    endfunction

endpackage

// File: rtl/ual_ctrl_memif.sv
// Memory request holder: registers req/we/addr/wdata on start and keeps them stable until ack.
module ual_ctrl_memif
    import ual_ctrl_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    input  logic              ack_i,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [15:0]       wdata_o,
    output logic              done_o
);

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;

    assign done_o = req_q & ack_i;

    // A start in the same cycle as done chains straight into the next transfer.
    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start_i) begin
            req_d   = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end else if (done_o) begin
            req_d = 1'b0;
            we_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign req_o   = req_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/ual_ctrl_seq.sv
// Accumulator-CPU control sequencer driving the UAL; owns PC, IR, ACCU, R1 and carry.
// Optional UAL_CTRL_HALT_EN turns op 001 into HALT instead of NOP.
module ual_ctrl_seq
    import ual_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [2:0]        sel_ual,
    output logic              ual_ce,
    output logic [15:0]       data_r1,
    output logic [15:0]       data_accu,
    input  logic [15:0]       ual_result,
    input  logic              ual_carry,
    output logic              carry_flag,
    output logic              halted
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       accu_q, accu_d;
    logic [15:0]       r1_q, r1_d;
    logic              carry_q, carry_d;

    logic              mem_done;
    logic              mem_start;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [2:0]        op;
    logic [ADDR_W-1:0] op_addr;

    assign op      = ir_q[15:13];
    assign op_addr = ir_q[ADDR_W-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        accu_d  = accu_q;
        r1_d    = r1_q;
        carry_d = carry_q;
        case (state_q)
            FETCH: begin
                if (mem_done) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (op)
                    OP_NOR, OP_ADD, OP_SUB, OP_LDA: state_d = OPRD;
                    OP_STA: state_d = WRITE;
                    OP_JCC: begin
                        if (!carry_q) pc_d = op_addr;
                        carry_d = 1'b0;
                        state_d = FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = op_addr;
                        state_d = FETCH;
                    end
                    default: begin
`ifdef UAL_CTRL_HALT_EN
                        state_d = HALTED;
`else
                        state_d = FETCH;
`endif
                    end
                endcase
            end
            OPRD: begin
                if (mem_done) begin
                    if (op == OP_LDA) begin
                        accu_d  = mem_rdata;
                        state_d = FETCH;
                    end else begin
                        r1_d    = mem_rdata;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                accu_d  = ual_result;
                carry_d = (op == OP_ADD || op == OP_SUB) ? ual_carry : 1'b0;
                state_d = FETCH;
            end
            WRITE: begin
                if (mem_done) state_d = FETCH;
            end
            HALTED: state_d = HALTED;
            default: state_d = FETCH;
        endcase

        // Launch a transfer on entry to a memory state so req is high in its first cycle.
        mem_start  = is_mem_state(state_d) && (!mem_req || mem_done);
        mem_we_n   = (state_d == WRITE);
        mem_addr_n = (state_d == FETCH) ? pc_d : op_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            accu_q  <= '0;
            r1_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            accu_q  <= accu_d;
            r1_q    <= r1_d;
            carry_q <= carry_d;
        end
    end

    ual_ctrl_memif #(.ADDR_W(ADDR_W)) u_memif (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mem_start),
        .we_i    (mem_we_n),
        .addr_i  (mem_addr_n),
        .wdata_i (accu_q),
        .ack_i   (mem_ack),
        .req_o   (mem_req),
        .we_o    (mem_we),
        .addr_o  (mem_addr),
        .wdata_o (mem_wdata),
        .done_o  (mem_done)
    );

    assign sel_ual    = (state_q == EXEC) ? op : SEL_IDLE;
    assign ual_ce     = (state_q == EXEC);
    assign data_r1    = r1_q;
    assign data_accu  = accu_q;
    assign carry_flag = carry_q;
`ifdef UAL_CTRL_HALT_EN
    assign halted     = (state_q == HALTED);
`else
    assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_ual_ctrl_seq.sv
// Bench for ual_ctrl_seq: wait-state memory, behavioural UAL, directed table, corner sequences, ISA-level random model.
module tb_ual_ctrl_seq;
    import ual_ctrl_pkg::*;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata, mem_rdata, data_r1, data_accu, ual_result;
    logic [2:0]    sel_ual;
    logic          ual_ce, ual_carry, carry_flag, halted;

    always #5 clk = ~clk;

    ual_ctrl_seq #(.ADDR_W(AW), .PC_RESET('0)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .sel_ual(sel_ual), .ual_ce(ual_ce), .data_r1(data_r1), .data_accu(data_accu),
        .ual_result(ual_result), .ual_carry(ual_carry),
        .carry_flag(carry_flag), .halted(halted)
    );

    // Behavioural UAL: NOR, ADD (carry out), SUB (borrow out), anything else neutral.
    always_comb begin
        ual_result = 16'h0;
        ual_carry  = 1'b0;
        case (sel_ual)
            3'b000: ual_result = ~(data_accu | data_r1);
            3'b010: {ual_carry, ual_result} = {1'b0, data_accu} + {1'b0, data_r1};
            3'b011: {ual_carry, ual_result} = {1'b0, data_accu} - {1'b0, data_r1};
            default: ;
        endcase
    end

    // Memory with programmable wait states
    logic [15:0] mem [0:8191];
    logic [15:0] mm  [0:8191];
    int ws = 0;
    int wcnt;
    assign mem_ack   = mem_req && (wcnt >= ws);
    assign mem_rdata = (mem_req && !mem_we) ? mem[mem_addr] : 16'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 wcnt <= 0;
        else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                        wcnt <= 0;
    end

    typedef struct {
        logic [12:0] addr;
        logic        we;
        logic [15:0] data;
        logic [15:0] accu;
        logic        c;
        int          cyc;
        logic        isf;
    } xfer_t;

    xfer_t act_q[$];
    xfer_t exp_q[$];
    int cyc = 0;
    int we_cycles, nor_cycles, ce_cycles, req_cycles;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        xfer_t t;
        if (rst_n) begin
            if (mem_req && mem_ack) begin
                t.addr = mem_addr; t.we = mem_we;
                t.data = mem_we ? mem_wdata : mem_rdata;
                t.accu = data_accu; t.c = carry_flag; t.cyc = cyc; t.isf = 1'b0;
                act_q.push_back(t);
                if (mem_we) mem[mem_addr] = mem_wdata;
            end
            if (mem_req && mem_we)            we_cycles++;
            if (ual_ce && sel_ual == 3'b000)  nor_cycles++;
            if (ual_ce)                       ce_cycles++;
            if (mem_req)                      req_cycles++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [2:0] op, input int a);
        return {op, 13'(a)};
    endfunction

    function automatic xfer_t get(input int i);
        xfer_t z;
        z = '{addr: 13'h0, we: 1'b0, data: 16'h0, accu: 16'h0, c: 1'b0, cyc: 0, isf: 1'b0};
        if (i < act_q.size()) z = act_q[i];
        return z;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) begin mem[i] = 16'h0; mm[i] = 16'h0; end
    endtask

    task automatic do_reset(input int w);
        rst_n = 1'b0;
        ws = w;
        @(negedge clk);
        act_q.delete();
        we_cycles = 0; nor_cycles = 0; ce_cycles = 0; req_cycles = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int k;
        k = 0;
        while (act_q.size() < n && k < budget) begin @(posedge clk); k++; end
        if (act_q.size() < n) begin
            checks++; errors++;
            $display("FAIL timeout: got %0d transfers expected %0d", act_q.size(), n);
        end
        @(negedge clk);
    endtask

    // ISA-level reference: executes the program, producing the transfer trace and fetch timing.
    task automatic push_x(input int a, input logic we, input logic [15:0] d);
        exp_q.push_back('{addr: 13'(a), we: we, data: d, accu: 16'h0, c: 1'b0, cyc: 0, isf: 1'b0});
    endtask

    task automatic model_run(input int n, input int w);
        int pc, t, a, s, cy, na;
        logic [15:0] acc, ir, d;
        logic c;
        logic [2:0] op;
        pc = 0; t = 0; acc = 16'h0; c = 1'b0;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            ir = mm[pc];
            exp_q.push_back('{addr: 13'(pc), we: 1'b0, data: ir, accu: acc, c: c, cyc: t, isf: 1'b1});
            op = ir[15:13]; a = int'(ir[12:0]); pc = (pc + 1) % 8192; d = mm[a];
            cy = 2; na = 1;
            case (op)
                OP_NOR: begin push_x(a, 1'b0, d); acc = ~(acc | d); c = 1'b0; cy = 4; na = 2; end
                OP_ADD: begin push_x(a, 1'b0, d); s = int'(acc) + int'(d); c = (s > 65535); acc = 16'(s); cy = 4; na = 2; end
                OP_SUB: begin push_x(a, 1'b0, d); s = int'(acc) - int'(d); c = (s < 0); acc = 16'(s); cy = 4; na = 2; end
                OP_LDA: begin push_x(a, 1'b0, d); acc = d; cy = 3; na = 2; end
                OP_STA: begin push_x(a, 1'b1, acc); mm[a] = acc; cy = 3; na = 2; end
                OP_JCC: begin if (!c) pc = a; c = 1'b0; end
                OP_JMP: pc = a;
                default: ;
            endcase
            t += cy + w * na;
        end
    endtask

    function automatic logic [15:0] rand_ins();
        logic [2:0] op;
        op = 3'($urandom_range(0, 7));
`ifdef UAL_CTRL_HALT_EN
        if (op == OP_NOP) op = OP_LDA;
`endif
        case (op)
            OP_JCC, OP_JMP: return ins(op, $urandom_range(0, 62));
            OP_NOP:         return ins(op, $urandom_range(0, 8191));
            default:        return ins(op, 64 + $urandom_range(0, 63));
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op2;
        logic [15:0] d10, d11, e_accu;
        logic        e_c;
    } vec_t;

    vec_t tv[6];

    initial begin
        tv[0] = '{OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, 1'b1};
        tv[1] = '{OP_NOR, 16'h00F0, 16'h0F00, 16'hF00F, 1'b0};
        tv[2] = '{OP_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b0};
        tv[3] = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b1};
        tv[4] = '{OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0};
        tv[5] = '{OP_LDA, 16'hAAAA, 16'h5555, 16'h5555, 1'b0};

        clear_mem();
        #1;
        chk("rst_outputs", {mem_req, mem_we, ual_ce, sel_ual, carry_flag, halted},
                           {1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0});
        chk("rst_regs", {data_accu, data_r1}, 32'h0);

        // Directed table: LDA 10; <op> 11; JMP 2, alternating zero and 3 wait states
        for (int i = 0; i < 6; i++) begin
            int w;
            xfer_t f1, f2;
            w = (i % 2) * 3;
            clear_mem();
            mem[0] = ins(OP_LDA, 10); mem[1] = ins(tv[i].op2, 11); mem[2] = ins(OP_JMP, 2);
            mem[10] = tv[i].d10; mem[11] = tv[i].d11;
            do_reset(w);
            wait_xfers(5, 200);
            f1 = get(2); f2 = get(4);
            chk($sformatf("tbl%0d_result", i), {get(4).addr, f2.accu, f2.c}, {13'd2, tv[i].e_accu, tv[i].e_c});
            chk($sformatf("tbl%0d_cycles", i), 64'(f2.cyc - f1.cyc),
                64'(((tv[i].op2 == OP_LDA) ? 3 : 4) + 2 * w));
            chk($sformatf("tbl%0d_ce", i), 64'(ce_cycles), 64'((tv[i].op2 == OP_LDA) ? 0 : 1));
            if (tv[i].op2 == OP_NOR) chk("nor_sel_once", 64'(nor_cycles), 64'd1);
        end

        // JCC: carry set -> falls through and clears; carry clear -> jumps
        clear_mem();
        mem[0] = ins(OP_LDA, 10); mem[1] = ins(OP_ADD, 11); mem[2] = ins(OP_JCC, 5);
        mem[3] = ins(OP_JCC, 20); mem[20] = ins(OP_JMP, 20);
        mem[10] = 16'hFFFF; mem[11] = 16'h0002;
        do_reset(0);
        wait_xfers(7, 200);
        chk("jcc_nojump", {get(4).c, get(5).addr, get(5).c}, {1'b1, 13'd3, 1'b0});
        chk("jcc_jump", {get(6).addr, 32'(get(6).cyc - get(5).cyc)}, {13'd20, 32'd2});

        // STA with 3 wait states
        clear_mem();
        mem[0] = ins(OP_LDA, 10); mem[1] = ins(OP_STA, 30); mem[2] = ins(OP_JMP, 2);
        mem[10] = 16'h5A5A;
        do_reset(3);
        wait_xfers(5, 200);
        chk("sta_xfer", {get(3).addr, get(3).we, get(3).data}, {13'd30, 1'b1, 16'h5A5A});
        chk("sta_req_cycles", 64'(we_cycles), 64'd4);
        chk("sta_mem", {48'h0, mem[30]}, 64'h5A5A);

        // PC wrap from the top of the address space
        clear_mem();
        mem[0] = ins(OP_JMP, 8191); mem[8191] = ins(OP_LDA, 10); mem[10] = 16'h7777;
        do_reset(0);
        wait_xfers(4, 200);
        chk("pc_wrap", {get(1).addr, get(3).addr, get(3).accu}, {13'd8191, 13'd0, 16'h7777});

        // Reset asserted during an operand-read wait
        begin
            int k;
            clear_mem();
            mem[0] = ins(OP_LDA, 10); mem[1] = ins(OP_LDA, 11); mem[10] = 16'h1234; mem[11] = 16'h4321;
            do_reset(3);
            k = 0;
            while (!(mem_req && mem_addr == 13'd11 && !mem_ack) && k < 100) begin @(negedge clk); k++; end
            chk("oprd_reached", {data_accu, mem_addr}, {16'h1234, 13'd11});
            rst_n = 1'b0;
            #1;
            chk("midrst_outputs", {mem_req, mem_we, ual_ce, sel_ual, carry_flag, halted},
                                  {1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0});
            chk("midrst_regs", {data_accu, data_r1}, 32'h0);
            do_reset(0);
            wait_xfers(1, 50);
            chk("restart_fetch", {get(0).addr, get(0).we}, {13'd0, 1'b0});
        end

        // Op 001
        clear_mem();
        mem[0] = ins(OP_NOP, 0); mem[1] = ins(OP_LDA, 10); mem[2] = ins(OP_JMP, 2); mem[10] = 16'hBEEF;
        do_reset(0);
`ifdef UAL_CTRL_HALT_EN
        wait_xfers(1, 50);
        repeat (2) @(negedge clk);
        req_cycles = 0;
        repeat (20) @(negedge clk);
        chk("halt_state", {halted, sel_ual, 32'(req_cycles)}, {1'b1, 3'b001, 32'd0});
`else
        wait_xfers(4, 100);
        chk("nop_advance", {get(1).addr, 32'(get(1).cyc - get(0).cyc), halted}, {13'd1, 32'd2, 1'b0});
        chk("nop_then_lda", {get(3).addr, get(3).accu}, {13'd2, 16'hBEEF});
`endif

        // Random programs against the ISA-level model
        for (int p = 0; p < 6; p++) begin
            int w, e0, c0;
            xfer_t r, e;
            w = $urandom_range(0, 3);
            clear_mem();
            for (int a = 0; a < 63; a++) mem[a] = rand_ins();
            mem[63] = ins(OP_JMP, 0);
            for (int a = 64; a < 128; a++) mem[a] = 16'($urandom);
            for (int a = 0; a < 128; a++) mm[a] = mem[a];
            model_run(30, w);
            do_reset(w);
            wait_xfers(exp_q.size(), 2000);
            e0 = errors;
            c0 = get(0).cyc;
            for (int i = 0; i < exp_q.size(); i++) begin
                r = get(i); e = exp_q[i];
                chk($sformatf("rand%0d_xfer%0d", p, i), {r.addr, r.we, r.data}, {e.addr, e.we, e.data});
                if (e.isf)
                    chk($sformatf("rand%0d_state%0d", p, i), {r.accu, r.c, 32'(r.cyc - c0)},
                        {e.accu, e.c, 32'(e.cyc)});
                if (errors != e0) break;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
